// File: rtl/rfblackwidow_stmerge.sv
// Store merge buffer: coalesces bus-width stores into cache-line writes drained oldest first.
// Define RFBW_STMERGE_TIMEOUT_EN to add per-entry idle counters that force a drain after TIMEOUT cycles.
module rfblackwidow_stmerge #(
  parameter int BUSWID  = 128,
  parameter int LINEWID = 512,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_adr_i,
  input  logic [BUSWID/8-1:0]  req_sel_i,
  input  logic [BUSWID-1:0]    req_dat_i,
  input  logic                 flush_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [31:0]          wr_adr_o,
  output logic [LINEWID-1:0]   wr_dat_o,
  output logic [LINEWID/8-1:0] wr_sel_o,
  output logic [LINEWID-1:0]   wr_mask_o,
  output logic                 empty_o
);

  localparam int NB    = BUSWID / 8;
  localparam int LB    = LINEWID / 8;
  localparam int OFFW  = $clog2(LB);
  localparam int BOFFW = $clog2(NB);
  localparam int TAGW  = 32 - OFFW;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 16 || TIMEOUT < 1 || TIMEOUT > 255 || LINEWID < BUSWID) begin : g_param_check
    $error("rfblackwidow_stmerge: parameter out of range");
  end

  typedef enum logic [0:0] {IDLE, PRESENT} state_t;

  state_t             state;
  logic [DEPTH-1:0]   ent_vld;
  logic [TAGW-1:0]    ent_tag [DEPTH];
  logic [LINEWID-1:0] ent_dat [DEPTH];
  logic [LB-1:0]      ent_sel [DEPTH];
  logic [IW-1:0]      ord_q   [DEPTH];
  logic [IW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      cnt, cnt_next;
  logic               flush_q;

  logic [TAGW-1:0]    req_tag;
  logic [31:0]        lane_idx;
  logic [LINEWID-1:0] req_dat_line, req_mask_line;
  logic [LB-1:0]      req_sel_line;
  logic [IW-1:0]      head, hit_idx, alloc_idx;
  logic [LINEWID-1:0] head_mask;
  logic               full, tmo_hit, eligible, lock_act, sel_zero, hit;
  logic               acc, do_merge, do_alloc, do_free;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_tag  = req_adr_i[31:OFFW];
  assign lane_idx = 32'(req_adr_i[OFFW-1:0]) >> BOFFW;
  assign head     = ord_q[rd_ptr];
  assign full     = (cnt == CW'(DEPTH));
  assign sel_zero = (req_sel_i == '0);

  always_comb begin
    req_sel_line = LB'(req_sel_i) << (lane_idx * NB);
    req_dat_line = LINEWID'(req_dat_i) << (lane_idx * BUSWID);
    req_mask_line = '0;
    head_mask = '0;
    for (int b = 0; b < LB; b++) begin
      req_mask_line[8*b +: 8] = {8{req_sel_line[b]}};
      head_mask[8*b +: 8]     = {8{ent_sel[head][b]}};
    end
  end

`ifdef RFBW_STMERGE_TIMEOUT_EN
  logic [7:0] ent_tmr [DEPTH];
  assign tmo_hit = (ent_tmr[head] >= 8'(TIMEOUT));
`else
  assign tmo_hit = 1'b0;
`endif

  // Only the oldest entry may drain; it is locked against merges from the
  // cycle its contents are captured into the wr_* registers.
  assign eligible = (cnt != '0) && ((&ent_sel[head]) || full || flush_q || tmo_hit);
  assign lock_act = (state == PRESENT) || eligible;

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_vld[i] && (ent_tag[i] == req_tag) && !(lock_act && (head == IW'(i)))) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!ent_vld[i]) alloc_idx = IW'(i);
    end
  end

  assign req_ready_o = sel_zero || hit || !full;
  assign acc         = req_valid_i && req_ready_o && !sel_zero;
  assign do_merge    = acc && hit;
  assign do_alloc    = acc && !hit;
  assign do_free     = (state == PRESENT) && wr_ready_i;
  assign cnt_next    = cnt + CW'(do_alloc) - CW'(do_free);

  // Entry storage, allocation-order queue, flush flag and the drain FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      ent_vld    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      flush_q    <= 1'b0;
      empty_o    <= 1'b1;
      wr_valid_o <= 1'b0;
      wr_adr_o   <= '0;
      wr_dat_o   <= '0;
      wr_sel_o   <= '0;
      wr_mask_o  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tag[i] <= '0;
        ent_dat[i] <= '0;
        ent_sel[i] <= '0;
        ord_q[i]   <= '0;
      end
    end else begin
      if (do_free) begin
        ent_vld[head] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      if (do_alloc) begin
        ent_vld[alloc_idx] <= 1'b1;
        ent_tag[alloc_idx] <= req_tag;
        ent_dat[alloc_idx] <= req_dat_line & req_mask_line;
        ent_sel[alloc_idx] <= req_sel_line;
        ord_q[wr_ptr]      <= alloc_idx;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (do_merge) begin
        ent_dat[hit_idx] <= (ent_dat[hit_idx] & ~req_mask_line) | (req_dat_line & req_mask_line);
        ent_sel[hit_idx] <= ent_sel[hit_idx] | req_sel_line;
      end
      cnt     <= cnt_next;
      empty_o <= (cnt_next == '0);
      flush_q <= flush_i || (flush_q && !empty_o);

      case (state)
        IDLE: begin
          if (eligible) begin
            state      <= PRESENT;
            wr_valid_o <= 1'b1;
            wr_adr_o   <= {ent_tag[head], {OFFW{1'b0}}};
            wr_dat_o   <= ent_dat[head];
            wr_sel_o   <= ent_sel[head];
            wr_mask_o  <= head_mask;
          end
        end
        PRESENT: begin
          if (wr_ready_i) begin
            state      <= IDLE;
            wr_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RFBW_STMERGE_TIMEOUT_EN
  // Idle counters restart on any write into the entry and saturate at 255.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent_tmr[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((do_alloc && (alloc_idx == IW'(i))) || (do_merge && (hit_idx == IW'(i))))
          ent_tmr[i] <= '0;
        else if (ent_vld[i] && (ent_tmr[i] != 8'hFF))
          ent_tmr[i] <= ent_tmr[i] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rfblackwidow_stmerge.sv
// Directed, table-driven bench for rfblackwidow_stmerge at default parameters.
// Honours RFBW_STMERGE_TIMEOUT_EN for the idle-timeout scenario.
module tb_rfblackwidow_stmerge;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [31:0]  req_adr_i = '0;
  logic [15:0]  req_sel_i = '0;
  logic [127:0] req_dat_i = '0;
  logic         flush_i = 1'b0;
  logic         wr_valid_o;
  logic         wr_ready_i = 1'b0;
  logic [31:0]  wr_adr_o;
  logic [511:0] wr_dat_o;
  logic [63:0]  wr_sel_o;
  logic [511:0] wr_mask_o;
  logic         empty_o;

  rfblackwidow_stmerge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
    .flush_i(flush_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_adr_o(wr_adr_o), .wr_dat_o(wr_dat_o), .wr_sel_o(wr_sel_o), .wr_mask_o(wr_mask_o),
    .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic         exp_ready;
  } vec_t;

  vec_t s1_vec[4];
  vec_t s2_vec[3];
  vec_t s3_vec[5];

  int           checks = 0;
  int           fails = 0;
  logic [511:0] exp_dat;
  logic [63:0]  exp_sel;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that samples the request.
  task automatic applyStimulus(input string name, input vec_t v);
    req_adr_i   = v.adr;
    req_sel_i   = v.sel;
    req_dat_i   = v.dat;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    checkOutput(name, 512'(req_ready_o), 512'(v.exp_ready));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic model_clear();
    exp_dat = '0;
    exp_sel = '0;
  endtask

  // Reference merge: later stores overwrite earlier bytes in the same lane.
  task automatic model_store(input vec_t v);
    int lane;
    lane = int'(v.adr[5:4]);
    for (int j = 0; j < 16; j++) begin
      if (v.sel[j]) begin
        exp_dat[(lane*16 + j)*8 +: 8] = v.dat[j*8 +: 8];
        exp_sel[lane*16 + j] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_write(input int max_cycles, output int n);
    n = 0;
    while (!wr_valid_o && n < max_cycles) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  task automatic complete_write();
    wr_ready_i = 1'b1;
    @(posedge clk_i); #1;
    wr_ready_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic expect_line(input string name, input logic [31:0] adr);
    int n;
    logic [511:0] mask;
    wait_write(20, n);
    for (int b = 0; b < 64; b++) mask[b*8 +: 8] = {8{exp_sel[b]}};
    checkOutput({name, "_valid"}, 512'(wr_valid_o), 512'(1));
    checkOutput({name, "_adr"}, 512'(wr_adr_o), 512'(adr));
    checkOutput({name, "_sel"}, 512'(wr_sel_o), 512'(exp_sel));
    checkOutput({name, "_dat"}, wr_dat_o, exp_dat);
    checkOutput({name, "_mask"}, wr_mask_o, mask);
    if (wr_valid_o) complete_write();
  endtask

  initial begin : main
    int n;
    logic ok;
    logic [31:0]  snap_adr;
    logic [511:0] snap_dat;
    logic [63:0]  snap_sel;
    vec_t v;

    for (int k = 0; k < 4; k++)
      s1_vec[k] = '{32'h100 + 32'(k*16), 16'hFFFF, {4{32'hC0DE_0000 + 32'(k)}}, 1'b1};
    s2_vec[0] = '{32'h200, 16'h000F, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_A4A3_A2A1, 1'b1};
    s2_vec[1] = '{32'h204, 16'h00F0, 128'hBBBB_BBBB_BBBB_BBBB_B8B7_B6B5_BBBB_BBBB, 1'b1};
    s2_vec[2] = '{32'h208, 16'h0018, 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCC5_C4CC_CCCC, 1'b1};
    for (int k = 0; k < 5; k++)
      s3_vec[k] = '{32'h1000 * 32'(k+1), 16'h0001, {16{8'(8'h10 + k)}}, (k < 4)};

    // Reset state
    #3 rst_ni = 1'b0;
    #1;
    checkOutput("rst_wr_valid", 512'(wr_valid_o), 512'(0));
    checkOutput("rst_empty", 512'(empty_o), 512'(1));
    checkOutput("rst_wr_adr", 512'(wr_adr_o), 512'(0));
    checkOutput("rst_wr_dat", wr_dat_o, 512'(0));
    checkOutput("rst_wr_sel", 512'(wr_sel_o), 512'(0));
    checkOutput("rst_wr_mask", wr_mask_o, 512'(0));
    checkOutput("rst_ready", 512'(req_ready_o), 512'(1));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // All-zero byte enables are accepted and dropped
    v = '{32'h500, 16'h0000, 128'h1234, 1'b1};
    applyStimulus("zero_sel_ready", v);
    idle(2);
    checkOutput("zero_sel_empty", 512'(empty_o), 512'(1));

    // Four lanes fill one line; write appears in the second cycle after the last accept
    model_clear();
    for (int k = 0; k < 4; k++) begin
      applyStimulus($sformatf("s1_ready%0d", k), s1_vec[k]);
      model_store(s1_vec[k]);
    end
    wait_write(10, n);
    checkOutput("s1_latency", 512'(n), 512'(1));
    checkOutput("s1_not_empty", 512'(empty_o), 512'(0));
    expect_line("s1", 32'h100);
    checkOutput("s1_empty_after", 512'(empty_o), 512'(1));
    checkOutput("s1_valid_after", 512'(wr_valid_o), 512'(0));
    idle(2);

    // Partial merges with overlap, drained by flush
    model_clear();
    for (int k = 0; k < 3; k++) begin
      applyStimulus($sformatf("s2_ready%0d", k), s2_vec[k]);
      model_store(s2_vec[k]);
    end
    pulse_flush();
    expect_line("s2", 32'h200);
    checkOutput("s2_sel_const", 512'(exp_sel), 512'(64'hFF));
    idle(4);
    checkOutput("s2_single_write", 512'(wr_valid_o), 512'(0));
    idle(2);

    // Single partial store: timeout drain when enabled, otherwise held until flush
    v = '{32'h600, 16'h0003, 128'h5A5A, 1'b1};
    applyStimulus("tmo_ready", v);
    model_clear();
    model_store(v);
    wait_write(40, n);
`ifdef RFBW_STMERGE_TIMEOUT_EN
    checkOutput("tmo_window", 512'(n >= 15 && n <= 17), 512'(1));
    expect_line("tmo", 32'h600);
`else
    checkOutput("tmo_no_write", 512'(wr_valid_o), 512'(0));
    pulse_flush();
    expect_line("tmo_flush", 32'h600);
`endif
    idle(3);

    // Five distinct lines into four entries with the cache stalled
    for (int k = 0; k < 4; k++) applyStimulus($sformatf("s3_ready%0d", k), s3_vec[k]);
    req_adr_i = s3_vec[4].adr;
    req_sel_i = s3_vec[4].sel;
    req_dat_i = s3_vec[4].dat;
    req_valid_i = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      ok &= (req_ready_o == 1'b0);
      @(posedge clk_i); #1;
    end
    checkOutput("s3_fifth_blocked", 512'(ok), 512'(1));
    model_clear();
    model_store(s3_vec[0]);
    expect_line("s3_0", s3_vec[0].adr);
    @(negedge clk_i);
    checkOutput("s3_fifth_ready", 512'(req_ready_o), 512'(1));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    pulse_flush();
    for (int k = 1; k < 5; k++) begin
      model_clear();
      model_store(s3_vec[k]);
      expect_line($sformatf("s3_%0d", k), s3_vec[k].adr);
    end
    idle(2);
    checkOutput("s3_empty", 512'(empty_o), 512'(1));
    idle(2);

    // Stalled presentation, same-tag store allocates a second entry
    v = '{32'h300, 16'h0003, 128'h0000_0000_0000_0000_0000_0000_0000_D2D1, 1'b1};
    applyStimulus("s4_first", v);
    pulse_flush();
    wait_write(10, n);
    checkOutput("s4_present", 512'(wr_valid_o), 512'(1));
    snap_adr = wr_adr_o;
    snap_dat = wr_dat_o;
    snap_sel = wr_sel_o;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) applyStimulus("s4_same_tag_ready",
                                '{32'h310, 16'h000F, 128'hE4E3_E2E1, 1'b1});
      else idle(1);
      ok &= wr_valid_o && (wr_adr_o == snap_adr) && (wr_dat_o == snap_dat) && (wr_sel_o == snap_sel);
    end
    checkOutput("s4_hold_stable", 512'(ok), 512'(1));
    model_clear();
    model_store(v);
    expect_line("s4_a", 32'h300);
    model_clear();
    model_store('{32'h310, 16'h000F, 128'hE4E3_E2E1, 1'b1});
    expect_line("s4_b", 32'h300);
    idle(2);
    checkOutput("s4_empty", 512'(empty_o), 512'(1));

    // Reset while presenting discards the line
    applyStimulus("s5_ready", '{32'h400, 16'h0001, 128'h77, 1'b1});
    pulse_flush();
    wait_write(10, n);
    checkOutput("s5_present", 512'(wr_valid_o), 512'(1));
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("s5_rst_valid", 512'(wr_valid_o), 512'(0));
    checkOutput("s5_rst_empty", 512'(empty_o), 512'(1));
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    ok = 1'b0;
    repeat (10) begin
      ok |= wr_valid_o;
      idle(1);
    end
    checkOutput("s5_no_replay", 512'(ok), 512'(0));
    checkOutput("s5_empty_after", 512'(empty_o), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
